// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage divider: FSM encodings and alu_op decode bit positions.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Div ops sit directly after the mul ops in the EX alu_op one-hot vector.
  localparam int unsigned ALU_OP_W      = 19;
  localparam int unsigned ALU_OP_MUL_W  = 12;
  localparam int unsigned ALU_OP_MULH_W = 13;
  localparam int unsigned ALU_OP_MULH_WU = 14;
  localparam int unsigned ALU_OP_DIV_W  = 15;
  localparam int unsigned ALU_OP_MOD_W  = 16;
  localparam int unsigned ALU_OP_DIV_WU = 17;
  localparam int unsigned ALU_OP_MOD_WU = 18;

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    trial   = {rem_i, dvd_bit_i};
    diff    = trial - {1'b0, dsr_i};
    q_bit_o = ~diff[WIDTH];
    // Either branch fits in WIDTH bits: diff < divisor, or trial < divisor.
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu with request/result handshakes.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             div_cancel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] div_q,
  output logic [WIDTH-1:0] div_r
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_e       state_q;
  logic             ready_q;
  logic             valid_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] src1_q;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             zero_div_q;

  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] rem_d;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] src1_abs;
  logic [WIDTH-1:0] src2_abs;
  logic             q_bit;
  logic             last_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .dsr_i     (dsr_q),
    .rem_o     (rem_d),
    .q_bit_o   (q_bit)
  );

  always_comb begin
    src1_abs  = (div_signed && div_src1[WIDTH-1]) ? -div_src1 : div_src1;
    src2_abs  = (div_signed && div_src2[WIDTH-1]) ? -div_src2 : div_src2;
    // Quotient bits enter at the LSB as dividend bits leave the MSB, so dvd_q ends as the quotient.
    dvd_d     = {dvd_q[WIDTH-2:0], q_bit};
    cnt_d     = cnt_q + CW'(1);
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= DIV_IDLE;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      src1_q     <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      zero_div_q <= 1'b0;
    end else if (div_cancel) begin
      state_q <= DIV_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (div_valid) begin
            state_q    <= DIV_BUSY;
            ready_q    <= 1'b0;
            dvd_q      <= src1_abs;
            dsr_q      <= src2_abs;
            rem_q      <= '0;
            src1_q     <= div_src1;
            cnt_q      <= '0;
            qneg_q     <= div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
            rneg_q     <= div_signed & div_src1[WIDTH-1];
            zero_div_q <= (div_src2 == '0);
          end
        end
        DIV_BUSY: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_d;
          if (last_step) begin
            state_q <= DIV_DONE;
            valid_q <= 1'b1;
          end
        end
        DIV_DONE: begin
          if (res_ready) begin
            state_q <= DIV_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= DIV_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    div_ready = ready_q;
    res_valid = valid_q;
    if (zero_div_q) begin
      div_q = '1;
      div_r = src1_q;
    end else begin
      div_q = qneg_q ? -dvd_q : dvd_q;
      div_r = rneg_q ? -rem_q : rem_q;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, monitor pops and compares.
module tb_div_unit;

  localparam int W = 32;

  logic          clk;
  logic          resetn;
  logic          div_valid;
  logic          div_ready;
  logic          div_signed;
  logic [W-1:0]  div_src1;
  logic [W-1:0]  div_src2;
  logic          div_cancel;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  div_q;
  logic [W-1:0]  div_r;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rr_rand = 0;
  bit   pv = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .div_cancel (div_cancel),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .div_q      (div_q),
    .div_r      (div_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: wide signed/unsigned arithmetic truncates toward zero; team rule for /0.
  function automatic exp_t model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int acc);
    exp_t   e;
    longint x;
    longint y;
    e.acc = acc;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else begin
      if (s) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end else begin
        x = longint'({32'd0, a});
        y = longint'({32'd0, b});
      end
      e.q = 32'(x / y);
      e.r = 32'(x % y);
    end
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    while (!div_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!div_ready) begin
      chk("issue_ready_timeout", 32'(div_ready), 32'd1);
      return;
    end
    div_valid  = 1'b1;
    div_signed = s;
    div_src1   = a;
    div_src2   = b;
    @(posedge clk);
    #1;
    sb.push_back(model(s, a, b, cyc));
    div_valid  = 1'b0;
    div_signed = 1'($urandom);
    div_src1   = W'($urandom);
    div_src2   = W'($urandom);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) chk("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: handshake tracking, latency, value and stability checks.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (resetn) begin
        chk("ready_vs_idle", 32'(div_ready), 32'(sb.size() == 0));
        if (res_valid) begin
          if (sb.size() == 0) begin
            chk("spurious_res_valid", 32'(res_valid), 32'd0);
          end else begin
            if (!pv) chk("latency", 32'(cyc - sb[0].acc), 32'(W));
            chk("div_q", div_q, sb[0].q);
            chk("div_r", div_r, sb[0].r);
            if (res_ready && !div_cancel) void'(sb.pop_front());
          end
        end
        pv = res_valid;
      end else begin
        pv = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rr_rand) res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    resetn     = 1'b0;
    div_valid  = 1'b0;
    div_signed = 1'b0;
    div_src1   = '0;
    div_src2   = '0;
    div_cancel = 1'b0;
    res_ready  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_div_q", div_q, 32'd0);
    chk("reset_div_r", div_r, 32'd0);
    chk("reset_ready", 32'(div_ready), 32'd1);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    issue(1'b0, 32'd100, 32'd7);
    drain();
    issue(1'b1, 32'hFFFF_FFF9, 32'h2);
    issue(1'b1, 32'h7, 32'hFFFF_FFFE);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b1, 32'h1234_5678, 32'h0);
    issue(1'b0, 32'h1234_5678, 32'h0);
    issue(1'b1, 32'hFFFF_FFF9, 32'h0);
    issue(1'b0, 32'hFFFF_FFFF, 32'h1);
    drain();

    res_ready = 1'b0;
    issue(1'b0, 32'd1000, 32'd33);
    wait_valid();
    repeat (5) @(negedge clk);
    res_ready = 1'b1;
    drain();

    issue(1'b0, 32'd12345, 32'd67);
    repeat (10) @(negedge clk);
    div_cancel = 1'b1;
    @(posedge clk);
    #1;
    void'(sb.pop_back());
    div_cancel = 1'b0;
    repeat (40) @(negedge clk);
    issue(1'b0, 32'd9, 32'd3);
    drain();

    issue(1'b1, 32'hDEAD_BEEF, 32'd77);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("midreset_div_q", div_q, 32'd0);
    chk("midreset_div_r", div_r, 32'd0);
    chk("midreset_ready", 32'(div_ready), 32'd1);
    chk("midreset_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);

    div_valid  = 1'b1;
    div_cancel = 1'b1;
    div_src1   = 32'd50;
    div_src2   = 32'd5;
    @(posedge clk);
    #1;
    div_valid  = 1'b0;
    div_cancel = 1'b0;
    chk("valid_with_cancel_ready", 32'(div_ready), 32'd1);
    repeat (40) @(negedge clk);

    @(negedge clk);
    rr_rand = 1'b1;
    for (int i = 0; i < 40; i++) issue(1'($urandom), pick(), pick());
    drain();
    rr_rand   = 1'b0;
    res_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
